mirfak_bus_arbiter: RTL and testbench
=====================================

# mirfak_bus_arbiter

Two-master, one-slave Wishbone (classic, single-beat) arbiter that shares the core's single external memory port between the instruction fetch unit (iport) and the load/store unit (dport). Sits between the fetch/LSU wishbone ports and the top-level memory bus. Its ack timing drives the fetch-ready and LSU-busy signals consumed by the pipeline controller. Grants are registered and locked per transaction, round-robin on contention. A watchdog aborts unanswered transactions.

## Interface
- TIMEOUT, default 255: cycles a granted strobe may wait for ack/err before abort; 0 disables the watchdog. Legal range 0..65535.

- clk_i  input  1  core clock; all state on rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low
- iport_addr_i  input  32  fetch address
- iport_cyc_i  input  1  fetch bus cycle request
- iport_stb_i  input  1  fetch strobe
- iport_ack_o  output  1  fetch ack, gated to owner
- iport_err_o  output  1  fetch error (slave err or abort), gated to owner
- dport_addr_i  input  32  LSU address
- dport_dat_i  input  32  LSU write data
- dport_sel_i  input  4  LSU byte select
- dport_we_i  input  1  LSU write enable
- dport_cyc_i  input  1  LSU bus cycle request
- dport_stb_i  input  1  LSU strobe
- dport_ack_o  output  1  LSU ack, gated to owner
- dport_err_o  output  1  LSU error, gated to owner
- rdata_o  output  32  read data, master_dat_i broadcast to both ports
- master_addr_o / master_dat_o  output  32  muxed address / write data
- master_sel_o  output  4  muxed byte select (4'hF when iport owns)
- master_we_o  output  1  muxed write enable (0 when iport owns)
- master_cyc_o / master_stb_o  output  1  owner's cyc/stb, forced 0 in IDLE/ABORT
- master_dat_i  input  32  slave read data
- master_ack_i / master_err_i  input  1  slave ack / error

## Operation
- States: IDLE, OWN_I, OWN_D, ABORT. Registered `last` bit (0=I, 1=D) for round-robin.
- Arbitration at an edge happens when the state is IDLE, or when the state is OWN_x and owner cyc_i is 0.
  - Only one cyc_i high: grant it.
  - Both high: grant the port not equal to `last`.
  - Neither high: go to IDLE.
  - `last` updates to the granted port on every grant.
- While in OWN_x with owner cyc_i=1, the grant is locked; the other port's request is held off (ack/err stay 0).
- Master outputs are combinational muxes of the owner's inputs selected by the state register. In IDLE: master_cyc_o=master_stb_o=master_we_o=0, addr/dat/sel=0.
- Ack/err routing: owner_ack_o=master_ack_i, owner_err_o=master_err_i. The non-owner gets 0. In IDLE all ack/err are 0.
- Watchdog: 16-bit counter.
  - Clears on any grant change, on ack/err, and whenever owner stb is low.
  - Increments each cycle owner stb_i=1 with no ack/err.
  - When count==TIMEOUT-1 and still no ack/err, next state is ABORT.
- ABORT, exactly one cycle: master_cyc_o=master_stb_o=0, aborted owner's err_o=1, then arbitrate as above. An owner still holding cyc after abort is treated as a new request.
- Slave ack/err arriving while in ABORT or IDLE is dropped.

## Timing
- Reset (rst_ni low, async): state=IDLE, last=0 (first contended grant goes to dport), counter=0. Every output is 0 during and immediately after reset.
- Grant latency: cyc_i rising at edge N−1 (arbiter in IDLE) → master_cyc_o high in cycle N (one registered cycle).
- Ack path is combinational: master_ack_i in cycle M → owner ack_o in cycle M, zero latency.
- Handover has no bubble: owner drops cyc at cycle M while the other port requests → other port owns from cycle M+1.
- Back-to-back by the same port: it keeps cyc high across transactions and stays granted even if the other port is waiting. Masters must drop cyc between transactions for fairness; the LSU and fetch unit already do so.
- Reset mid-transaction: the bus is released immediately (asynchronously); the in-flight ack is lost.

## Test plan
- Reset with both cyc=1 → all outputs 0 while rst_ni=0. First edge after release grants dport; master_we_o/sel_o equal dport values from the next cycle.
- iport only, addr 0x80000000, slave acks 2 cycles after stb → iport_ack_o in the same cycle as master_ack_i, rdata_o=master_dat_i, dport_ack_o=0. sel=4'hF and we=0 throughout.
- Both request continuously, each dropping cyc one cycle after ack → grants alternate D, I, D, I with no idle cycle between owners.
- Slave asserts err on a dport write → dport_err_o=1 for that cycle only, iport unaffected, state returns to arbitration.
- TIMEOUT=4, slave never responds to iport → master_stb_o high for 4 cycles. Then 1 ABORT cycle with master_cyc_o=0 and iport_err_o=1. A pending dport request is granted the following cycle.
- TIMEOUT=0 with slave silent for 1000 cycles → no abort, grant held. An ack at cycle 1000 completes normally.

Source files
------------

// File: rtl/mirfak_bus_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter sharing the external memory port
// between instruction fetch (iport) and load/store (dport). Grants are registered,
// locked for the owner's cycle, round-robin on contention, with an abort watchdog.
module mirfak_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] iport_addr_i,
  input  logic        iport_cyc_i,
  input  logic        iport_stb_i,
  output logic        iport_ack_o,
  output logic        iport_err_o,
  input  logic [31:0] dport_addr_i,
  input  logic [31:0] dport_dat_i,
  input  logic [3:0]  dport_sel_i,
  input  logic        dport_we_i,
  input  logic        dport_cyc_i,
  input  logic        dport_stb_i,
  output logic        dport_ack_o,
  output logic        dport_err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] master_addr_o,
  output logic [31:0] master_dat_o,
  output logic [3:0]  master_sel_o,
  output logic        master_we_o,
  output logic        master_cyc_o,
  output logic        master_stb_o,
  input  logic [31:0] master_dat_i,
  input  logic        master_ack_i,
  input  logic        master_err_i
);

  typedef enum logic [1:0] {StIdle, StOwnI, StOwnD, StAbort} state_e;

  // TIMEOUT == 0 disables the watchdog; the limit is then never compared.
  localparam bit          WdogEn = (TIMEOUT != 0);
  localparam logic [15:0] Limit  = WdogEn ? 16'(TIMEOUT - 1) : 16'd0;

  state_e      state_q, state_d;
  logic        last_q, last_d;              // 0 = iport granted last, 1 = dport
  logic        abort_dport_q, abort_dport_d; // which port the pending abort belongs to
  logic [15:0] cnt_q, cnt_d;

  logic own_cyc, own_stb, resp, locked;

  // Owner's request lines as seen through the current grant.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    unique case (state_q)
      StOwnI: begin
        own_cyc = iport_cyc_i;
        own_stb = iport_stb_i;
      end
      StOwnD: begin
        own_cyc = dport_cyc_i;
        own_stb = dport_stb_i;
      end
      default: ;
    endcase
  end

  assign resp   = master_ack_i | master_err_i;
  assign locked = ((state_q == StOwnI) || (state_q == StOwnD)) && own_cyc;

  // Next-state: hold the locked grant and run the watchdog, otherwise arbitrate.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    abort_dport_d = abort_dport_q;
    cnt_d         = cnt_q;
    if (locked) begin
      if (resp || !own_stb) begin
        cnt_d = '0;
      end else if (WdogEn && (cnt_q == Limit)) begin
        state_d       = StAbort;
        abort_dport_d = (state_q == StOwnD);
        cnt_d         = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      // IDLE, ABORT, or owner released cyc: a still-held cyc counts as a fresh request.
      cnt_d = '0;
      if (iport_cyc_i && dport_cyc_i) begin
        state_d = last_q ? StOwnI : StOwnD;
        last_d  = ~last_q;
      end else if (iport_cyc_i) begin
        state_d = StOwnI;
        last_d  = 1'b0;
      end else if (dport_cyc_i) begin
        state_d = StOwnD;
        last_d  = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Grant, round-robin and watchdog state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      last_q        <= 1'b0;
      abort_dport_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      abort_dport_q <= abort_dport_d;
      cnt_q         <= cnt_d;
    end
  end

  // Master-side mux and ack/err routing, selected by the registered grant only.
  always_comb begin
    master_addr_o = '0;
    master_dat_o  = '0;
    master_sel_o  = '0;
    master_we_o   = 1'b0;
    master_cyc_o  = 1'b0;
    master_stb_o  = 1'b0;
    iport_ack_o   = 1'b0;
    iport_err_o   = 1'b0;
    dport_ack_o   = 1'b0;
    dport_err_o   = 1'b0;
    unique case (state_q)
      StOwnI: begin
        master_addr_o = iport_addr_i;
        master_sel_o  = 4'hF;
        master_cyc_o  = iport_cyc_i;
        master_stb_o  = iport_stb_i;
        iport_ack_o   = master_ack_i;
        iport_err_o   = master_err_i;
      end
      StOwnD: begin
        master_addr_o = dport_addr_i;
        master_dat_o  = dport_dat_i;
        master_sel_o  = dport_sel_i;
        master_we_o   = dport_we_i;
        master_cyc_o  = dport_cyc_i;
        master_stb_o  = dport_stb_i;
        dport_ack_o   = master_ack_i;
        dport_err_o   = master_err_i;
      end
      StAbort: begin
        iport_err_o = ~abort_dport_q;
        dport_err_o = abort_dport_q;
      end
      default: ;
    endcase
  end

  assign rdata_o = master_dat_i;

endmodule

// File: tb/tb_mirfak_bus_arbiter.sv
// Directed bench for mirfak_bus_arbiter: a TIMEOUT=4 instance and a TIMEOUT=0 instance
// share the same stimulus; expected transactions are queued when requests are driven.
module tb_mirfak_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr, d_addr, d_dat, s_dat;
  logic        i_cyc, i_stb, d_cyc, d_stb, d_we, s_ack, s_err;
  logic [3:0]  d_sel;

  logic        i_ack4, i_err4, d_ack4, d_err4, m_we4, m_cyc4, m_stb4;
  logic [31:0] rdata4, m_addr4, m_dat4;
  logic [3:0]  m_sel4;
  logic        i_ack0, i_err0, d_ack0, d_err0, m_we0, m_cyc0, m_stb0;
  logic [31:0] rdata0, m_addr0, m_dat0;
  logic [3:0]  m_sel0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        port;  // 0 = iport, 1 = dport
    logic [31:0] addr;
    logic [31:0] rdata;
  } txn_t;
  txn_t exp_q[$];

  always #5 clk = ~clk;

  mirfak_bus_arbiter #(.TIMEOUT(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .iport_addr_i(i_addr), .iport_cyc_i(i_cyc), .iport_stb_i(i_stb),
    .iport_ack_o(i_ack4), .iport_err_o(i_err4),
    .dport_addr_i(d_addr), .dport_dat_i(d_dat), .dport_sel_i(d_sel), .dport_we_i(d_we),
    .dport_cyc_i(d_cyc), .dport_stb_i(d_stb), .dport_ack_o(d_ack4), .dport_err_o(d_err4),
    .rdata_o(rdata4), .master_addr_o(m_addr4), .master_dat_o(m_dat4), .master_sel_o(m_sel4),
    .master_we_o(m_we4), .master_cyc_o(m_cyc4), .master_stb_o(m_stb4),
    .master_dat_i(s_dat), .master_ack_i(s_ack), .master_err_i(s_err)
  );

  mirfak_bus_arbiter #(.TIMEOUT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .iport_addr_i(i_addr), .iport_cyc_i(i_cyc), .iport_stb_i(i_stb),
    .iport_ack_o(i_ack0), .iport_err_o(i_err0),
    .dport_addr_i(d_addr), .dport_dat_i(d_dat), .dport_sel_i(d_sel), .dport_we_i(d_we),
    .dport_cyc_i(d_cyc), .dport_stb_i(d_stb), .dport_ack_o(d_ack0), .dport_err_o(d_err0),
    .rdata_o(rdata0), .master_addr_o(m_addr0), .master_dat_o(m_dat0), .master_sel_o(m_sel0),
    .master_we_o(m_we0), .master_cyc_o(m_cyc0), .master_stb_o(m_stb0),
    .master_dat_i(s_dat), .master_ack_i(s_ack), .master_err_i(s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve the oldest queued transaction on the TIMEOUT=4 instance. Called in the first
  // cycle the owner should hold the grant; returns in the cycle after the ack with the
  // owner's cyc dropped.
  task automatic serve_one(input int lat);
    txn_t t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    t = exp_q.pop_front();
    #1;
    chk("own_cyc", 64'(m_cyc4), 64'd1);
    chk("own_addr", 64'(m_addr4), 64'(t.addr));
    chk("own_we", 64'(m_we4), t.port ? 64'(d_we) : 64'd0);
    chk("own_sel", 64'(m_sel4), t.port ? 64'(d_sel) : 64'hF);
    chk("own_dat", 64'(m_dat4), t.port ? 64'(d_dat) : 64'd0);
    for (int k = 0; k < lat; k++) begin
      step();
      chk("wait_noack", 64'({i_ack4, d_ack4}), 64'd0);
      chk("wait_sel", 64'(m_sel4), t.port ? 64'(d_sel) : 64'hF);
    end
    s_ack = 1'b1;
    s_dat = t.rdata;
    #1;
    chk("ack_owner", t.port ? 64'(d_ack4) : 64'(i_ack4), 64'd1);
    chk("ack_other", t.port ? 64'(i_ack4) : 64'(d_ack4), 64'd0);
    chk("rdata", 64'(rdata4), 64'(t.rdata));
    step();
    s_ack = 1'b0;
    s_dat = '0;
    if (t.port) begin
      d_cyc = 1'b0;
      d_stb = 1'b0;
    end else begin
      i_cyc = 1'b0;
      i_stb = 1'b0;
    end
    #1;
    chk("ack_drop", 64'({i_ack4, d_ack4}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ok_cnt;

    // Reset with both masters requesting.
    rst_n  = 1'b0;
    i_addr = 32'h0000_1000;
    i_cyc  = 1'b1;
    i_stb  = 1'b1;
    d_addr = 32'h0000_2000;
    d_dat  = 32'hDEAD_BEEF;
    d_sel  = 4'h3;
    d_we   = 1'b1;
    d_cyc  = 1'b1;
    d_stb  = 1'b1;
    s_dat  = '0;
    s_ack  = 1'b0;
    s_err  = 1'b0;
    exp_q.push_back('{port: 1'b1, addr: 32'h0000_2000, rdata: 32'h1111_0001});
    exp_q.push_back('{port: 1'b0, addr: 32'h0000_1000, rdata: 32'h2222_0002});
    exp_q.push_back('{port: 1'b1, addr: 32'h0000_2000, rdata: 32'h3333_0003});
    exp_q.push_back('{port: 1'b0, addr: 32'h0000_1000, rdata: 32'h4444_0004});
    repeat (3) @(posedge clk);
    #1;
    chk("rst_zero4", 64'(|{i_ack4, i_err4, d_ack4, d_err4, rdata4, m_addr4, m_dat4, m_sel4,
                          m_we4, m_cyc4, m_stb4}), 64'd0);
    chk("rst_zero0", 64'(|{i_ack0, i_err0, d_ack0, d_err0, rdata0, m_addr0, m_dat0, m_sel0,
                          m_we0, m_cyc0, m_stb0}), 64'd0);
    #3;
    rst_n = 1'b1;
    #1;
    chk("post_rst_zero", 64'(|{i_ack4, i_err4, d_ack4, d_err4, m_addr4, m_sel4, m_we4,
                              m_cyc4, m_stb4}), 64'd0);

    // Contended alternation: D first after reset, then I, D, I with no idle owner.
    step();
    serve_one(0);
    step();
    d_cyc = 1'b1;
    d_stb = 1'b1;
    serve_one(1);
    step();
    i_cyc = 1'b1;
    i_stb = 1'b1;
    serve_one(2);
    step();
    d_cyc = 1'b1;
    d_stb = 1'b1;
    serve_one(0);
    d_cyc = 1'b0;
    d_stb = 1'b0;

    // Idle: stray slave ack must not reach either port.
    step();
    s_ack = 1'b1;
    #1;
    chk("idle_cyc", 64'(m_cyc4), 64'd0);
    chk("idle_ack_drop", 64'({i_ack4, d_ack4}), 64'd0);
    s_ack = 1'b0;

    // iport only, ack two cycles after strobe.
    i_addr = 32'h8000_0000;
    i_cyc  = 1'b1;
    i_stb  = 1'b1;
    exp_q.push_back('{port: 1'b0, addr: 32'h8000_0000, rdata: 32'h1234_5678});
    step();
    serve_one(2);
    step();

    // dport write error while iport waits (last was iport, so dport wins).
    d_addr = 32'h0000_3000;
    d_dat  = 32'hCAFE_F00D;
    d_sel  = 4'hC;
    d_we   = 1'b1;
    d_cyc  = 1'b1;
    d_stb  = 1'b1;
    i_cyc  = 1'b1;
    i_stb  = 1'b1;
    step();
    chk("err_own_addr", 64'(m_addr4), 64'h3000);
    s_err = 1'b1;
    #1;
    chk("err_dport", 64'(d_err4), 64'd1);
    chk("err_iport_clean", 64'({i_err4, i_ack4, d_ack4}), 64'd0);
    step();
    s_err = 1'b0;
    #1;
    chk("err_one_cycle", 64'(d_err4), 64'd0);
    d_cyc = 1'b0;
    d_stb = 1'b0;
    step();
    chk("err_handover", 64'(m_addr4), 64'h8000_0000);
    i_cyc = 1'b0;
    i_stb = 1'b0;
    step();
    chk("err_idle", 64'(m_cyc4), 64'd0);

    // Watchdog: iport silent, dport pending; TIMEOUT=4 aborts, TIMEOUT=0 holds.
    i_cyc = 1'b1;
    i_stb = 1'b1;
    step();
    d_cyc = 1'b1;
    d_stb = 1'b1;
    #1;
    n = 0;
    while (m_stb4 && n < 20) begin
      n++;
      step();
    end
    chk("wd_stb_cycles", 64'(n), 64'd4);
    chk("wd_abort_cyc", 64'({m_cyc4, m_stb4}), 64'd0);
    chk("wd_abort_ierr", 64'(i_err4), 64'd1);
    chk("wd_abort_derr", 64'(d_err4), 64'd0);
    step();
    chk("wd_next_grant", 64'({m_cyc4, m_addr4}), {31'd0, 1'b1, 32'h0000_3000});
    chk("wd0_hold", 64'({m_cyc0, m_addr0}), {31'd0, 1'b1, 32'h8000_0000});

    // TIMEOUT=0 instance keeps the iport grant through 1000 silent cycles.
    ok_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (m_cyc0 && m_stb0 && !i_err0 && (m_addr0 == 32'h8000_0000)) ok_cnt++;
    end
    chk("nowd_hold_cycles", 64'(ok_cnt), 64'd1000);
    s_ack = 1'b1;
    s_dat = 32'h600D_F00D;
    #1;
    chk("nowd_ack", 64'({i_ack0, d_ack0}), 64'b10);
    chk("nowd_rdata", 64'(rdata0), 64'h600D_F00D);
    step();
    s_ack = 1'b0;
    s_dat = '0;
    i_cyc = 1'b0;
    i_stb = 1'b0;
    d_cyc = 1'b0;
    d_stb = 1'b0;
    step();
    step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
